// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin burst arbiter:
// FSM state encoding and default datapath/burst sizing.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_t;

  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 16;

endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// 2:1 data selector shared by both requesters.
// sel=0 passes IN1, sel=1 passes IN2.
module TwoToOneMux #(
  parameter int W = 32
) (
  input  logic [W-1:0] IN1,
  input  logic [W-1:0] IN2,
  input  logic         sel,
  output logic [W-1:0] out
);

  assign out = sel ? IN2 : IN1;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter: locks a 2:1 data path to one requester per burst
// and registers the winner's beats into a single valid/ready output stage.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              mux_sel,
  output logic [1:0]        grant,
  output logic              burst_trunc,
  output logic              dbg_state
);

  localparam int CNT_W = $clog2(MAX_BURST);

  // Handshake rule: a beat moves on any cycle where valid && ready are both
  // high at the rising edge; valid must not depend on ready.

  arb_state_t          r_state;
  arb_state_t          w_next_state;
  logic                r_ptr;
  logic                r_owner;
  logic [1:0]          r_grant;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_last;
  logic                r_trunc;

  logic [DATA_W-1:0]   w_sel_data;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic                w_own_ready;
  logic                w_accept;
  logic                w_cap;
  logic                w_end;
  logic                w_any_req;
  logic                w_winner;

  TwoToOneMux #(.W(DATA_W)) u_sel_mux (
    .IN1 (in0_data),
    .IN2 (in1_data),
    .sel (r_owner),
    .out (w_sel_data)
  );

  assign w_sel_valid = r_owner ? in1_valid : in0_valid;
  assign w_sel_last  = r_owner ? in1_last  : in0_last;
  assign w_own_ready = (r_state == ST_OWN) && (!r_out_valid || out_ready);
  assign w_accept    = w_own_ready && w_sel_valid;
  assign w_cap       = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
  assign w_end       = w_accept && (w_sel_last || w_cap);
  assign w_any_req   = in0_valid || in1_valid;
  // Contention goes to the pointer; a lone requester wins outright.
  assign w_winner    = (in0_valid && in1_valid) ? r_ptr : in1_valid;

  assign in0_ready   = w_own_ready && !r_owner;
  assign in1_ready   = w_own_ready &&  r_owner;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign mux_sel     = r_owner;
  assign grant       = r_grant;
  assign burst_trunc = r_trunc;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_next_state = ST_OWN;
      ST_OWN:  if (w_end)     w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_grant    <= 2'b00;
      r_beat_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any_req) begin
        r_owner    <= w_winner;
        r_grant    <= w_winner ? 2'b10 : 2'b01;
        r_beat_cnt <= '0;
      end
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      if (w_end) begin
        r_ptr   <= ~r_owner;
        r_grant <= 2'b00;
      end
    end
  end

  // Output register: loads on accept, drains on out_ready, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_trunc     <= 1'b0;
    end else begin
      r_trunc <= w_accept && w_cap && !w_sel_last;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_last  <= w_sel_last || w_cap;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: arbitration order, burst locking,
// MAX_BURST truncation, backpressure and asynchronous reset.
module tb_mux_rr_arbiter;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          in0_valid, in1_valid;
  logic [DW-1:0] in0_data, in1_data;
  logic          in0_last, in1_last;
  logic          in0_ready, in1_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_ready;
  logic          mux_sel;
  logic [1:0]    grant;
  logic          burst_trunc;
  logic          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  mux_rr_arbiter #(.DATA_W(DW), .MAX_BURST(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in0_valid   (in0_valid),
    .in0_data    (in0_data),
    .in0_last    (in0_last),
    .in0_ready   (in0_ready),
    .in1_valid   (in1_valid),
    .in1_data    (in1_data),
    .in1_last    (in1_last),
    .in1_ready   (in1_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .mux_sel     (mux_sel),
    .grant       (grant),
    .burst_trunc (burst_trunc),
    .dbg_state   (dbg_state)
  );

  // Clock and global time bound
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks a freshly registered beat and queues it for the handshake monitor.
  task automatic check_beat(input string tag, input logic [DW-1:0] d, input logic l);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_last"}, {31'd0, out_last}, {31'd0, l});
    exp_q.push_back(d);
  endtask

  task automatic drive0(input logic v, input logic [DW-1:0] d, input logic l);
    in0_valid = v; in0_data = d; in0_last = l;
  endtask

  task automatic drive1(input logic v, input logic [DW-1:0] d, input logic l);
    in1_valid = v; in1_data = d; in1_last = l;
  endtask

  // Scoreboard: every downstream handshake must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL sb_extra_beat: observed=%0h expected=none", out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        assert (out_data === e) else begin
          n_fail++;
          $error("FAIL sb_order: observed=%0h expected=%0h", out_data, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive0(1'b0, '0, 1'b0);
    drive1(1'b0, '0, 1'b0);
    tick(); tick();

    // Reset values
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_mux_sel", {31'd0, mux_sel}, 32'd0);
    check("rst_trunc", {31'd0, burst_trunc}, 32'd0);
    check("rst_ready", {30'd0, in1_ready, in0_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_no_req_grant", {30'd0, grant}, 32'd0);

    // Single requester in1, three-beat burst
    drive1(1'b1, 32'hA1, 1'b0);
    tick();
    check("t1_grant", {30'd0, grant}, 32'd2);
    check("t1_mux_sel", {31'd0, mux_sel}, 32'd1);
    check("t1_no_beat_in_idle", {31'd0, out_valid}, 32'd0);
    check("t1_ready", {30'd0, in1_ready, in0_ready}, 32'd2);
    tick(); check_beat("t1_b1", 32'hA1, 1'b0);
    drive1(1'b1, 32'hA2, 1'b0);
    tick(); check_beat("t1_b2", 32'hA2, 1'b0);
    drive1(1'b1, 32'hA3, 1'b1);
    tick(); check_beat("t1_b3", 32'hA3, 1'b1);
    check("t1_grant_release", {30'd0, grant}, 32'd0);
    drive1(1'b0, '0, 1'b0);
    tick();
    check("t1_drain", {31'd0, out_valid}, 32'd0);

    // Both requesting, two-beat bursts: grants alternate 01,10,01,10
    drive0(1'b1, 32'h10, 1'b0);
    drive1(1'b1, 32'h20, 1'b0);
    tick(); check("t2_g1", {30'd0, grant}, 32'd1);
    check("t2_g1_ready", {30'd0, in1_ready, in0_ready}, 32'd1);
    tick(); check_beat("t2_b10", 32'h10, 1'b0);
    drive0(1'b1, 32'h11, 1'b1);
    tick(); check_beat("t2_b11", 32'h11, 1'b1);
    drive0(1'b1, 32'h12, 1'b0);
    tick(); check("t2_g2", {30'd0, grant}, 32'd2);
    check("t2_g2_sel", {31'd0, mux_sel}, 32'd1);
    check("t2_idle_gap", {31'd0, out_valid}, 32'd0);
    tick(); check_beat("t2_b20", 32'h20, 1'b0);
    drive1(1'b1, 32'h21, 1'b1);
    tick(); check_beat("t2_b21", 32'h21, 1'b1);
    drive1(1'b1, 32'h22, 1'b0);
    tick(); check("t2_g3", {30'd0, grant}, 32'd1);
    tick(); check_beat("t2_b12", 32'h12, 1'b0);
    drive0(1'b1, 32'h13, 1'b1);
    tick(); check_beat("t2_b13", 32'h13, 1'b1);
    drive0(1'b0, '0, 1'b0);
    tick(); check("t2_g4", {30'd0, grant}, 32'd2);
    tick(); check_beat("t2_b22", 32'h22, 1'b0);
    drive1(1'b1, 32'h23, 1'b1);
    tick(); check_beat("t2_b23", 32'h23, 1'b1);
    drive1(1'b0, '0, 1'b0);
    tick();

    // in0 stream without last: forced end after 16 beats, then in1 has priority
    drive0(1'b1, 32'h100, 1'b0);
    drive1(1'b1, 32'h55, 1'b1);
    tick(); check("t3_grant", {30'd0, grant}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_beat($sformatf("t3_b%0d", i), 32'h100 + i, (i == 15));
      check($sformatf("t3_trunc%0d", i), {31'd0, burst_trunc}, {31'd0, (i == 15)});
      drive0(1'b1, 32'h100 + i + 1, 1'b0);
    end
    check("t3_grant_release", {30'd0, grant}, 32'd0);
    tick();
    check("t3_in1_wins", {30'd0, grant}, 32'd2);
    check("t3_trunc_pulse_end", {31'd0, burst_trunc}, 32'd0);
    tick(); check_beat("t3_in1", 32'h55, 1'b1);
    drive1(1'b0, '0, 1'b0);

    // Backpressure: remaining in0 beats with out_ready low for 4 cycles
    tick(); check("t4_grant", {30'd0, grant}, 32'd1);
    tick(); check_beat("t4_b0", 32'h110, 1'b0);
    out_ready = 1'b0;
    drive0(1'b1, 32'h111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t4_hold_data%0d", i), out_data, 32'h110);
      check($sformatf("t4_hold_valid%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("t4_hold_ready%0d", i), {30'd0, in1_ready, in0_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick(); check_beat("t4_b1", 32'h111, 1'b0);
    drive0(1'b1, 32'h112, 1'b1);
    tick(); check_beat("t4_b2", 32'h112, 1'b1);
    drive0(1'b0, '0, 1'b0);
    tick(); check("t4_drain", {31'd0, out_valid}, 32'd0);

    // Owner (in1) drops valid for 3 cycles; in0 waits until in1's last
    drive1(1'b1, 32'h30, 1'b0);
    tick(); check("t5_grant", {30'd0, grant}, 32'd2);
    tick(); check_beat("t5_b30", 32'h30, 1'b0);
    drive1(1'b0, 32'h30, 1'b0);
    drive0(1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t5_lock_grant%0d", i), {30'd0, grant}, 32'd2);
      check($sformatf("t5_lock_state%0d", i), {31'd0, dbg_state}, 32'd1);
      check($sformatf("t5_lock_in0rdy%0d", i), {31'd0, in0_ready}, 32'd0);
      check($sformatf("t5_lock_outv%0d", i), {31'd0, out_valid}, 32'd0);
    end
    drive1(1'b1, 32'h31, 1'b1);
    tick(); check_beat("t5_b31", 32'h31, 1'b1);
    drive1(1'b0, '0, 1'b0);
    tick(); check("t5_in0_grant", {30'd0, grant}, 32'd1);
    tick(); check_beat("t5_b40", 32'h40, 1'b1);
    drive0(1'b0, '0, 1'b0);
    tick();

    // Reset mid-burst: outputs clear at once, pointer back to in0
    drive1(1'b1, 32'h77, 1'b0);
    tick(); check("t6_grant", {30'd0, grant}, 32'd2);
    tick(); check_beat("t6_b77", 32'h77, 1'b0);
    drive1(1'b1, 32'h78, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    drive0(1'b1, 32'h90, 1'b1);
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    check("t6_rst_grant", {30'd0, grant}, 32'd0);
    check("t6_rst_sel", {31'd0, mux_sel}, 32'd0);
    check("t6_rst_ready", {30'd0, in1_ready, in0_ready}, 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); check("t6_ptr_in0", {30'd0, grant}, 32'd1);
    tick(); check_beat("t6_b90", 32'h90, 1'b1);
    drive0(1'b0, '0, 1'b0);
    drive1(1'b0, '0, 1'b0);
    tick(); tick();
    check("sb_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
